// File: rtl/iter_alu.sv
// Execute-stage ALU with a start/busy/done handshake.
// Single-cycle logic, arithmetic and shift ops, plus iterative unsigned
// MUL (shift-add) and DIV (restoring). The unit owns the condition-code
// register {NF,OF,CF,ZF} and its interrupt shadow copy.
module iter_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   aluSignals,
  input  logic [WIDTH-1:0] firstOperand,
  input  logic [WIDTH-1:0] secondOperand,
  input  logic             freeze,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHigh,
  output logic [3:0]       ccr,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastStep = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ShiftMax = WIDTH'(WIDTH);
  localparam logic [WIDTH:0]   OneExt   = {{WIDTH{1'b0}}, 1'b1};

  localparam int ZfBit = 0;
  localparam int CfBit = 1;
  localparam int OfBit = 2;
  localparam int NfBit = 3;

  localparam logic [OPW-1:0] OpNot  = OPW'(1);
  localparam logic [OPW-1:0] OpInc  = OPW'(2);
  localparam logic [OPW-1:0] OpDec  = OPW'(3);
  localparam logic [OPW-1:0] OpMov  = OPW'(4);
  localparam logic [OPW-1:0] OpAdd  = OPW'(5);
  localparam logic [OPW-1:0] OpSub  = OPW'(6);
  localparam logic [OPW-1:0] OpAnd  = OPW'(7);
  localparam logic [OPW-1:0] OpOr   = OPW'(8);
  localparam logic [OPW-1:0] OpShl  = OPW'(9);
  localparam logic [OPW-1:0] OpShr  = OPW'(10);
  localparam logic [OPW-1:0] OpSetc = OPW'(11);
  localparam logic [OPW-1:0] OpClrc = OPW'(12);
  localparam logic [OPW-1:0] OpRti  = OPW'(13);
  localparam logic [OPW-1:0] OpMul  = OPW'(14);
  localparam logic [OPW-1:0] OpDiv  = OPW'(15);

  typedef enum logic [1:0] {Idle, MulRun, DivRun} stateT;

  stateT           state;
  logic [CntW-1:0] stepCnt;
  logic [3:0]      shadow;

  // Iteration datapath registers (loaded on start, no reset needed)
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mulHi;
  logic [WIDTH-1:0] mulLo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Single-cycle op results
  logic [WIDTH:0]   addExt;
  logic [WIDTH:0]   subExt;
  logic [WIDTH:0]   incExt;
  logic [WIDTH:0]   decExt;
  logic [WIDTH:0]   shlExt;
  logic [WIDTH:0]   shrExt;
  logic [WIDTH-1:0] scRes;
  logic [WIDTH-1:0] scHigh;
  logic [3:0]       scCcr;
  logic             scDz;
  logic             startMul;
  logic             startDiv;

  // One iteration step of MUL / DIV
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHiNext;
  logic [WIDTH-1:0] mulLoNext;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH:0]   divDiff;
  logic             divFits;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quotNext;
  logic             lastIter;

  // Next-state values of the registered outputs
  logic             finish;
  logic [WIDTH-1:0] resNext;
  logic [WIDTH-1:0] highNext;
  logic [3:0]       ccrNext;
  logic             dzNext;

  // Refresh ZF/NF from a result, leaving CF/OF as given.
  function automatic logic [3:0] setZn(input logic [3:0] flags,
                                       input logic [WIDTH-1:0] value);
    logic [3:0] f;
    f        = flags;
    f[ZfBit] = (value == '0);
    f[NfBit] = value[WIDTH-1];
    return f;
  endfunction

  // Two's-complement overflow of x + y producing s.
  function automatic logic addOverflow(input logic signed [WIDTH-1:0] x,
                                       input logic signed [WIDTH-1:0] y,
                                       input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Two's-complement overflow of x - y producing s.
  function automatic logic subOverflow(input logic signed [WIDTH-1:0] x,
                                       input logic signed [WIDTH-1:0] y,
                                       input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Logical left shift; returns {last bit shifted out, shifted value}.
  // Shifting inside a 2*WIDTH window makes bit WIDTH the carry for
  // every amount 1..WIDTH and 0 for amount 0.
  function automatic logic [WIDTH:0] shiftLeft(input logic [WIDTH-1:0] value,
                                               input logic [WIDTH-1:0] amount);
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH:0]     res;
    ext = {{WIDTH{1'b0}}, value} << amount;
    if (amount > ShiftMax) res = '0;
    else                   res = {ext[WIDTH], ext[WIDTH-1:0]};
    return res;
  endfunction

  // Logical right shift; returns {last bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shiftRight(input logic [WIDTH-1:0] value,
                                                input logic [WIDTH-1:0] amount);
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH:0]     res;
    ext = {value, {WIDTH{1'b0}}} >> amount;
    if (amount > ShiftMax) res = '0;
    else                   res = {ext[WIDTH-1], ext[2*WIDTH-1:WIDTH]};
    return res;
  endfunction

  // Decode and evaluate the single-cycle ops straight from the ports.
  always_comb begin
    scRes    = '0;
    scHigh   = '0;
    scCcr    = ccr;
    scDz     = 1'b0;
    addExt   = {1'b0, firstOperand} + {1'b0, secondOperand};
    subExt   = {1'b0, firstOperand} - {1'b0, secondOperand};
    incExt   = {1'b0, firstOperand} + OneExt;
    decExt   = {1'b0, firstOperand} - OneExt;
    shlExt   = shiftLeft(firstOperand, secondOperand);
    shrExt   = shiftRight(firstOperand, secondOperand);
    startMul = (aluSignals == OpMul);
    startDiv = (aluSignals == OpDiv) && (secondOperand != '0);
    case (aluSignals)
      OpNot: begin
        scRes = ~firstOperand;
        scCcr = setZn(ccr, ~firstOperand);
      end
      OpInc: begin
        scRes        = incExt[WIDTH-1:0];
        scCcr        = setZn(ccr, incExt[WIDTH-1:0]);
        scCcr[CfBit] = incExt[WIDTH];
      end
      OpDec: begin
        scRes        = decExt[WIDTH-1:0];
        scCcr        = setZn(ccr, decExt[WIDTH-1:0]);
        scCcr[CfBit] = decExt[WIDTH];
      end
      OpMov: scRes = secondOperand;
      OpAdd: begin
        scRes        = addExt[WIDTH-1:0];
        scCcr        = setZn(ccr, addExt[WIDTH-1:0]);
        scCcr[CfBit] = addExt[WIDTH];
        scCcr[OfBit] = addOverflow(firstOperand, secondOperand, addExt[WIDTH-1:0]);
      end
      OpSub: begin
        scRes        = subExt[WIDTH-1:0];
        scCcr        = setZn(ccr, subExt[WIDTH-1:0]);
        scCcr[CfBit] = subExt[WIDTH];
        scCcr[OfBit] = subOverflow(firstOperand, secondOperand, subExt[WIDTH-1:0]);
      end
      OpAnd: begin
        scRes = firstOperand & secondOperand;
        scCcr = setZn(ccr, firstOperand & secondOperand);
      end
      OpOr: begin
        scRes = firstOperand | secondOperand;
        scCcr = setZn(ccr, firstOperand | secondOperand);
      end
      OpShl: begin
        scRes        = shlExt[WIDTH-1:0];
        scCcr        = setZn(ccr, shlExt[WIDTH-1:0]);
        scCcr[CfBit] = shlExt[WIDTH];
      end
      OpShr: begin
        scRes        = shrExt[WIDTH-1:0];
        scCcr        = setZn(ccr, shrExt[WIDTH-1:0]);
        scCcr[CfBit] = shrExt[WIDTH];
      end
      OpSetc: scCcr[CfBit] = 1'b1;
      OpClrc: scCcr[CfBit] = 1'b0;
      OpRti:  scCcr = shadow;
      OpDiv: begin
        // Only reached as a single-cycle op when the divisor is zero.
        scRes  = '1;
        scHigh = firstOperand;
        scDz   = 1'b1;
      end
      default: ;
    endcase
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mulSum    = {1'b0, mulHi} + (mulLo[0] ? {1'b0, mcand} : '0);
    mulHiNext = mulSum[WIDTH:1];
    mulLoNext = {mulSum[0], mulLo[WIDTH-1:1]};
    // Partial remainder is always below the divisor, so the trial value
    // fits WIDTH+1 bits and a clear top bit of the difference means "fits".
    divTrial  = {rem, quot[WIDTH-1]};
    divDiff   = divTrial - {1'b0, divisor};
    divFits   = ~divDiff[WIDTH];
    remNext   = divFits ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0];
    quotNext  = {quot[WIDTH-2:0], divFits};
  end

  assign lastIter = (stepCnt == LastStep);

  // Select what the output registers and the CCR take at this edge.
  always_comb begin
    finish   = 1'b0;
    resNext  = result;
    highNext = resultHigh;
    ccrNext  = ccr;
    dzNext   = divByZero;
    case (state)
      Idle: begin
        if (start && !startMul && !startDiv) begin
          finish   = 1'b1;
          resNext  = scRes;
          highNext = scHigh;
          ccrNext  = scCcr;
          dzNext   = scDz;
        end
      end
      MulRun: begin
        if (lastIter) begin
          finish         = 1'b1;
          resNext        = mulLoNext;
          highNext       = mulHiNext;
          dzNext         = 1'b0;
          ccrNext[ZfBit] = ({mulHiNext, mulLoNext} == '0);
          ccrNext[NfBit] = mulHiNext[WIDTH-1];
          ccrNext[CfBit] = (mulHiNext != '0);
        end
      end
      DivRun: begin
        if (lastIter) begin
          finish         = 1'b1;
          resNext        = quotNext;
          highNext       = remNext;
          dzNext         = 1'b0;
          ccrNext[ZfBit] = (quotNext == '0);
          ccrNext[CfBit] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, iteration registers, CCR/shadow and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= Idle;
      stepCnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      divByZero  <= 1'b0;
      result     <= '0;
      resultHigh <= '0;
      ccr        <= '0;
      shadow     <= '0;
    end else begin
      done       <= finish;
      result     <= resNext;
      resultHigh <= highNext;
      ccr        <= ccrNext;
      divByZero  <= dzNext;
      if (freeze) shadow <= ccrNext;
      case (state)
        Idle: begin
          stepCnt <= '0;
          if (start && startMul) begin
            state <= MulRun;
            busy  <= 1'b1;
            mcand <= firstOperand;
            mulHi <= '0;
            mulLo <= secondOperand;
          end else if (start && startDiv) begin
            state   <= DivRun;
            busy    <= 1'b1;
            divisor <= secondOperand;
            rem     <= '0;
            quot    <= firstOperand;
          end
        end
        MulRun: begin
          mulHi   <= mulHiNext;
          mulLo   <= mulLoNext;
          stepCnt <= stepCnt + CntW'(1);
          if (lastIter) begin
            state <= Idle;
            busy  <= 1'b0;
          end
        end
        DivRun: begin
          rem     <= remNext;
          quot    <= quotNext;
          stepCnt <= stepCnt + CntW'(1);
          if (lastIter) begin
            state <= Idle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= Idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu (WIDTH=16): a reference model pushes the
// expected outputs of each issued op into a queue, which is popped and
// compared when the unit raises done.
module tb_iter_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         freeze = 1'b0;
  logic [4:0]   aluSignals = '0;
  logic [W-1:0] firstOperand = '0;
  logic [W-1:0] secondOperand = '0;
  logic [W-1:0] result;
  logic [W-1:0] resultHigh;
  logic [3:0]   ccr;
  logic         busy;
  logic         done;
  logic         divByZero;

  iter_alu #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .aluSignals(aluSignals),
    .firstOperand(firstOperand), .secondOperand(secondOperand),
    .freeze(freeze), .result(result), .resultHigh(resultHigh),
    .ccr(ccr), .busy(busy), .done(done), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] high;
    logic [3:0]   ccr;
    logic         dz;
    int           lat;
  } expT;

  expT          sbQ[$];
  int           errors = 0;
  int           checks = 0;
  logic [3:0]   mCcr = '0;
  logic [3:0]   mShadow = '0;
  logic [W-1:0] lastRes = '0;
  logic [W-1:0] lastHigh = '0;
  logic         lastDz = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] zn(input logic [3:0] c, input logic [W-1:0] v);
    logic [3:0] f;
    f    = c;
    f[0] = (v == '0);
    f[3] = v[W-1];
    return f;
  endfunction

  // Reference behaviour; flags are {NF,OF,CF,ZF}.
  function automatic expT model(input logic [4:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [3:0] c,
                                input logic [3:0] sh);
    expT e;
    int s, ss, amt;
    logic [31:0] pr;
    e.res = '0; e.high = '0; e.ccr = c; e.dz = 1'b0; e.lat = 1;
    amt = int'(b);
    case (op)
      5'd1: begin e.res = ~a; e.ccr = zn(c, e.res); end
      5'd2: begin e.res = a + 16'd1; e.ccr = zn(c, e.res); e.ccr[1] = (a == 16'hFFFF); end
      5'd3: begin e.res = a - 16'd1; e.ccr = zn(c, e.res); e.ccr[1] = (a == 16'h0000); end
      5'd4: e.res = b;
      5'd5: begin
        s  = int'(a) + int'(b);
        ss = int'($signed(a)) + int'($signed(b));
        e.res = s[15:0]; e.ccr = zn(c, e.res);
        e.ccr[1] = s[16];
        e.ccr[2] = (ss > 32767) || (ss < -32768);
      end
      5'd6: begin
        s  = int'(a) - int'(b);
        ss = int'($signed(a)) - int'($signed(b));
        e.res = s[15:0]; e.ccr = zn(c, e.res);
        e.ccr[1] = (a < b);
        e.ccr[2] = (ss > 32767) || (ss < -32768);
      end
      5'd7: begin e.res = a & b; e.ccr = zn(c, e.res); end
      5'd8: begin e.res = a | b; e.ccr = zn(c, e.res); end
      5'd9: begin
        if (amt == 0) begin e.res = a; e.ccr[1] = 1'b0; end
        else if (amt <= 16) begin e.res = a << amt; e.ccr[1] = a[4'(16 - amt)]; end
        else begin e.res = '0; e.ccr[1] = 1'b0; end
        e.ccr = zn(e.ccr, e.res);
      end
      5'd10: begin
        if (amt == 0) begin e.res = a; e.ccr[1] = 1'b0; end
        else if (amt <= 16) begin e.res = a >> amt; e.ccr[1] = a[4'(amt - 1)]; end
        else begin e.res = '0; e.ccr[1] = 1'b0; end
        e.ccr = zn(e.ccr, e.res);
      end
      5'd11: e.ccr[1] = 1'b1;
      5'd12: e.ccr[1] = 1'b0;
      5'd13: e.ccr = sh;
      5'd14: begin
        pr = 32'(a) * 32'(b);
        e.res = pr[15:0]; e.high = pr[31:16];
        e.ccr[0] = (pr == 32'd0); e.ccr[3] = pr[31]; e.ccr[1] = (pr[31:16] != 16'd0);
        e.lat = 17;
      end
      5'd15: begin
        if (b == '0) begin e.res = 16'hFFFF; e.high = a; e.dz = 1'b1; end
        else begin
          e.res = a / b; e.high = a % b;
          e.ccr[0] = (e.res == '0); e.ccr[1] = 1'b0;
          e.lat = 17;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one op at a negedge and follow it to done. intrudeAt pulses a
  // second start (ADD) in that cycle; resetAt drops rst in that cycle.
  task automatic runOp(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic frz, input int intrudeAt,
                       input int resetAt);
    expT e, ex;
    int cyc;
    logic busyOk, aborted;
    e = model(op, a, b, mCcr, mShadow);
    if (resetAt == 0) sbQ.push_back(e);
    if (frz) mShadow = (e.lat == 1) ? e.ccr : mCcr;
    mCcr = e.ccr;
    aluSignals = op; firstOperand = a; secondOperand = b; freeze = frz; start = 1'b1;
    @(negedge clk);
    start = 1'b0; freeze = 1'b0;
    cyc = 1; busyOk = 1'b1; aborted = 1'b0;
    while (!done && !aborted && cyc < 40) begin
      if (!busy) busyOk = 1'b0;
      if (cyc == intrudeAt) begin
        start = 1'b1; aluSignals = 5'd5; firstOperand = 16'h0101; secondOperand = 16'h0202;
      end
      if (cyc == resetAt) begin rst = 1'b0; aborted = 1'b1; end
      @(negedge clk);
      start = 1'b0; rst = 1'b1;
      cyc++;
    end
    if (aborted) begin
      check({tag, " abort res"}, 32'({result, resultHigh}), 32'd0);
      check({tag, " abort ctl"}, 32'({ccr, busy, done, divByZero}), 32'd0);
      mCcr = '0; mShadow = '0; lastRes = '0; lastHigh = '0; lastDz = 1'b0;
      return;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, cyc, e.lat);
    check({tag, " busy run"}, 32'(busyOk), 32'd1);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    checks++;
    assert (sbQ.size() != 0) else begin
      errors++;
      $error("FAIL %s queue: got empty expected one entry", tag);
    end
    if (sbQ.size() != 0) begin
      ex = sbQ.pop_front();
      check({tag, " result"}, 32'(result), 32'(ex.res));
      check({tag, " resultHigh"}, 32'(resultHigh), 32'(ex.high));
      check({tag, " ccr"}, 32'(ccr), 32'(ex.ccr));
      check({tag, " divByZero"}, 32'(divByZero), 32'(ex.dz));
      lastRes = ex.res; lastHigh = ex.high; lastDz = ex.dz;
    end
  endtask

  // One quiet cycle: done must have dropped and outputs must hold.
  task automatic idleCheck(input string tag);
    @(negedge clk);
    check({tag, " pulse"}, 32'({busy, done}), 32'd0);
    check({tag, " hold"}, {result, resultHigh}, {lastRes, lastHigh});
    check({tag, " hold ccr"}, 32'({ccr, divByZero}), 32'({mCcr, lastDz}));
  endtask

  task automatic freezeOnly();
    freeze = 1'b1;
    @(negedge clk);
    freeze = 1'b0;
    mShadow = mCcr;
    check("freeze idle", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset res", {result, resultHigh}, 32'd0);
    check("reset ctl", 32'({ccr, busy, done, divByZero}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    runOp("add ovf", 5'd5, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
    check("plan add res", 32'(result), 32'h8000);
    check("plan add ccr", 32'(ccr), 32'hC);
    idleCheck("add");

    runOp("mul max", 5'd14, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0);
    check("plan mul prod", {resultHigh, result}, 32'hFFFE0001);
    check("plan mul flags", 32'({ccr[3], ccr[1], ccr[0]}), 32'h6);
    idleCheck("mul");

    runOp("div 100/7", 5'd15, 16'd100, 16'd7, 1'b0, 0, 0);
    check("plan div", {result, resultHigh}, {16'd14, 16'd2});
    check("plan div flags", 32'({ccr[1], ccr[0]}), 32'd0);
    runOp("div by 0", 5'd15, 16'd5, 16'd0, 1'b0, 0, 0);
    check("plan div0", {result, resultHigh}, {16'hFFFF, 16'd5});
    idleCheck("div0");
    runOp("not clears dz", 5'd1, 16'h00FF, 16'h0000, 1'b0, 0, 0);
    runOp("div small", 5'd15, 16'd3, 16'd10, 1'b0, 0, 0);
    runOp("div by 1", 5'd15, 16'hFFFF, 16'd1, 1'b0, 0, 0);

    runOp("or", 5'd8, 16'h0001, 16'h0000, 1'b0, 0, 0);
    runOp("setc", 5'd11, 16'h1234, 16'h5678, 1'b0, 0, 0);
    freezeOnly();
    runOp("sub zero", 5'd6, 16'd5, 16'd5, 1'b0, 0, 0);
    check("plan sub flags", 32'({ccr[1], ccr[0]}), 32'd1);
    runOp("rti", 5'd13, 16'h0000, 16'h0000, 1'b0, 0, 0);
    check("plan rti flags", 32'({ccr[1], ccr[0]}), 32'd2);
    idleCheck("rti");

    runOp("shl 1", 5'd9, 16'h8001, 16'd1, 1'b0, 0, 0);
    check("plan shl", 32'({ccr[1], result}), 32'h10002);
    runOp("shr 17", 5'd10, 16'h0001, 16'd17, 1'b0, 0, 0);
    check("plan shr", 32'({ccr[1], ccr[0], result}), 32'h10000);
    runOp("shr 16", 5'd10, 16'h8000, 16'd16, 1'b0, 0, 0);
    runOp("shl 16", 5'd9, 16'h0003, 16'd16, 1'b0, 0, 0);
    runOp("shl 0", 5'd9, 16'hA5A5, 16'd0, 1'b0, 0, 0);
    runOp("shr 4", 5'd10, 16'hF0F8, 16'd4, 1'b0, 0, 0);

    runOp("inc wrap", 5'd2, 16'hFFFF, 16'h0000, 1'b0, 0, 0);
    runOp("dec wrap", 5'd3, 16'h0000, 16'h0000, 1'b0, 0, 0);
    runOp("and", 5'd7, 16'hF0F0, 16'h0FF0, 1'b0, 0, 0);
    runOp("mov", 5'd4, 16'h1111, 16'hBEEF, 1'b0, 0, 0);
    runOp("sub borrow", 5'd6, 16'h8000, 16'h0001, 1'b0, 0, 0);
    runOp("nop", 5'd0, 16'h1234, 16'h4321, 1'b0, 0, 0);
    runOp("illegal op", 5'd20, 16'h1234, 16'h4321, 1'b0, 0, 0);
    runOp("clrc", 5'd12, 16'h0000, 16'h0000, 1'b0, 0, 0);
    idleCheck("misc");

    runOp("add+freeze", 5'd5, 16'hFFFF, 16'h0002, 1'b1, 0, 0);
    runOp("and zero", 5'd7, 16'h00F0, 16'h0F00, 1'b0, 0, 0);
    runOp("rti after frz", 5'd13, 16'h0000, 16'h0000, 1'b0, 0, 0);
    runOp("setc 2", 5'd11, 16'h0000, 16'h0000, 1'b0, 0, 0);
    freezeOnly();
    runOp("clrc 2", 5'd12, 16'h0000, 16'h0000, 1'b0, 0, 0);
    runOp("rti+freeze", 5'd13, 16'h0000, 16'h0000, 1'b1, 0, 0);
    runOp("clrc 3", 5'd12, 16'h0000, 16'h0000, 1'b0, 0, 0);
    runOp("rti again", 5'd13, 16'h0000, 16'h0000, 1'b0, 0, 0);
    check("plan rti freeze cf", 32'(ccr[1]), 32'd1);
    idleCheck("freeze");

    runOp("mul intruded", 5'd14, 16'h1234, 16'h5678, 1'b0, 5, 0);
    runOp("mul b2b", 5'd14, 16'h0000, 16'h9999, 1'b0, 0, 0);
    runOp("div b2b", 5'd15, 16'hFFFE, 16'h00FF, 1'b0, 0, 0);
    idleCheck("b2b");

    runOp("mul reset", 5'd14, 16'h00FF, 16'h0100, 1'b0, 0, 8);
    runOp("add after rst", 5'd5, 16'h0010, 16'h0020, 1'b0, 0, 0);
    runOp("mul after rst", 5'd14, 16'h0003, 16'h0005, 1'b0, 0, 0);
    idleCheck("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
